// File: rtl/trunc_selection_if.sv
// Bus bundle for trunc_selection: population/fitness in, ranked survivors out.
// The master side drives start/pop/fit; the slave side is the selection stage.
interface trunc_selection_if #(
    parameter int IND_W = 150,
    parameter int POP_N = 50,
    parameter int SEL_K = 10,
    parameter int FIT_W = 16
);
    logic                     start;
    logic [POP_N*IND_W-1:0]   pop;
    logic [POP_N*FIT_W-1:0]   fit;
    logic [SEL_K*IND_W-1:0]   sel_pop;
    logic [SEL_K*FIT_W-1:0]   sel_fit;
    logic                     busy;
    logic                     done;

    modport master (
        output start, pop, fit,
        input  sel_pop, sel_fit, busy, done
    );

    modport slave (
        input  start, pop, fit,
        output sel_pop, sel_fit, busy, done
    );
endinterface

// File: rtl/trunc_selection.sv
// Truncation selection: scans POP_N individuals one per clock, keeps a sorted
// best-SEL_K list by insertion, then publishes it best-first with a done pulse.
//
// state  | meaning
// S_IDLE | waiting for start, outputs hold the previous result
// S_SCAN | one individual inserted per clock, r_idx walks 0..POP_N-1
// S_DONE | result just published, done high for this cycle only
module trunc_selection #(
    parameter int IND_W    = 150,
    parameter int POP_N    = 50,
    parameter int SEL_K    = 10,
    parameter int FIT_W    = 16,
    parameter int MAXIMISE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    trunc_selection_if.slave sel_if
);
    localparam int IDX_W = (POP_N > 1) ? $clog2(POP_N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_N - 1);

    generate
        if (SEL_K < 1 || SEL_K > POP_N) begin : g_bad_sel_k
            $error("trunc_selection: SEL_K must lie in 1..POP_N");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_busy;
    logic               w_done;
    logic [IDX_W-1:0]   r_idx;

    logic [FIT_W-1:0]   w_fit_arr [POP_N];
    logic [IND_W-1:0]   w_ind_arr [POP_N];
    logic [FIT_W-1:0]   w_cand_fit;
    logic [IND_W-1:0]   w_cand_ind;

    logic               r_vld     [SEL_K];
    logic [FIT_W-1:0]   r_fit     [SEL_K];
    logic [IND_W-1:0]   r_ind     [SEL_K];
    logic               w_beat    [SEL_K];
    logic               w_vld_nxt [SEL_K];
    logic [FIT_W-1:0]   w_fit_nxt [SEL_K];
    logic [IND_W-1:0]   w_ind_nxt [SEL_K];
    logic [FIT_W-1:0]   r_sel_fit [SEL_K];
    logic [IND_W-1:0]   r_sel_ind [SEL_K];

    genvar gi;
    generate
        for (gi = 0; gi < POP_N; gi++) begin : g_unpack
            assign w_fit_arr[gi] = sel_if.fit[gi*FIT_W +: FIT_W];
            assign w_ind_arr[gi] = sel_if.pop[gi*IND_W +: IND_W];
        end
        for (gi = 0; gi < SEL_K; gi++) begin : g_pack
            assign sel_if.sel_fit[gi*FIT_W +: FIT_W] = r_sel_fit[gi];
            assign sel_if.sel_pop[gi*IND_W +: IND_W] = r_sel_ind[gi];
        end
    endgenerate

    assign w_cand_fit = w_fit_arr[r_idx];
    assign w_cand_ind = w_ind_arr[r_idx];

    // Valid slots are kept sorted with invalid ones at the tail, so w_beat is
    // monotonic: once set at slot p it stays set for every later slot.
    always_comb begin
        for (int k = 0; k < SEL_K; k++) begin
            w_beat[k] = !r_vld[k] ||
                        ((MAXIMISE != 0) ? (w_cand_fit > r_fit[k]) : (w_cand_fit < r_fit[k]));
        end
        for (int k = 0; k < SEL_K; k++) begin
            w_vld_nxt[k] = r_vld[k];
            w_fit_nxt[k] = r_fit[k];
            w_ind_nxt[k] = r_ind[k];
        end
        if (w_beat[0]) begin
            w_vld_nxt[0] = 1'b1;
            w_fit_nxt[0] = w_cand_fit;
            w_ind_nxt[0] = w_cand_ind;
        end
        for (int k = 1; k < SEL_K; k++) begin
            if (w_beat[k]) begin
                if (w_beat[k-1]) begin
                    w_vld_nxt[k] = r_vld[k-1];
                    w_fit_nxt[k] = r_fit[k-1];
                    w_ind_nxt[k] = r_ind[k-1];
                end else begin
                    w_vld_nxt[k] = 1'b1;
                    w_fit_nxt[k] = w_cand_fit;
                    w_ind_nxt[k] = w_cand_ind;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sel_if.start) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                w_busy = 1'b1;
                if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx <= '0;
            for (int k = 0; k < SEL_K; k++) begin
                r_vld[k]     <= 1'b0;
                r_fit[k]     <= '0;
                r_ind[k]     <= '0;
                r_sel_fit[k] <= '0;
                r_sel_ind[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sel_if.start) begin
                        r_idx <= '0;
                        for (int k = 0; k < SEL_K; k++) r_vld[k] <= 1'b0;
                    end
                end
                S_SCAN: begin
                    for (int k = 0; k < SEL_K; k++) begin
                        r_vld[k] <= w_vld_nxt[k];
                        r_fit[k] <= w_fit_nxt[k];
                        r_ind[k] <= w_ind_nxt[k];
                    end
                    // Publish directly from the insertion network so the last
                    // individual lands in the result on the edge entering DONE.
                    if (r_idx == LAST_IDX) begin
                        for (int k = 0; k < SEL_K; k++) begin
                            r_sel_fit[k] <= w_fit_nxt[k];
                            r_sel_ind[k] <= w_ind_nxt[k];
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel_if.busy = w_busy;
    assign sel_if.done = w_done;
endmodule

// File: tb/tb_trunc_selection.sv
// Directed bench for trunc_selection: a minimising and a maximising instance
// share clock, reset and stimulus; every expected value is hand-computed.
module tb_trunc_selection;
    localparam int IND_W = 8;
    localparam int POP_N = 8;
    localparam int SEL_K = 3;
    localparam int FIT_W = 8;

    // fit index0..7 = 7,3,9,1,5,8,2,6 packed with index 0 in the low byte
    localparam logic [63:0] FIT_BASIC = 64'h06_02_08_05_01_09_03_07;
    localparam logic [63:0] FIT_TIES  = 64'h04_04_04_04_04_04_04_04;
    localparam logic [63:0] POP_ALL   = 64'hA7_A6_A5_A4_A3_A2_A1_A0;

    localparam logic [23:0] MIN_FIT_BASIC = 24'h03_02_01;
    localparam logic [23:0] MIN_POP_BASIC = 24'hA1_A6_A3;
    localparam logic [23:0] MAX_FIT_BASIC = 24'h07_08_09;
    localparam logic [23:0] MAX_POP_BASIC = 24'hA0_A5_A2;
    localparam logic [23:0] FIT_TIE_RES   = 24'h04_04_04;
    localparam logic [23:0] POP_TIE_RES   = 24'hA2_A1_A0;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    trunc_selection_if #(.IND_W(IND_W), .POP_N(POP_N), .SEL_K(SEL_K), .FIT_W(FIT_W)) if_min ();
    trunc_selection_if #(.IND_W(IND_W), .POP_N(POP_N), .SEL_K(SEL_K), .FIT_W(FIT_W)) if_max ();

    trunc_selection #(.IND_W(IND_W), .POP_N(POP_N), .SEL_K(SEL_K), .FIT_W(FIT_W), .MAXIMISE(0))
        u_dut_min (.clk(clk), .rst_n(rst_n), .sel_if(if_min));
    trunc_selection #(.IND_W(IND_W), .POP_N(POP_N), .SEL_K(SEL_K), .FIT_W(FIT_W), .MAXIMISE(1))
        u_dut_max (.clk(clk), .rst_n(rst_n), .sel_if(if_max));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [63:0] f);
        if_min.start = st;
        if_max.start = st;
        if_min.fit   = f;
        if_max.fit   = f;
        if_min.pop   = POP_ALL;
        if_max.pop   = POP_ALL;
    endtask

    task automatic test_reset();
        drive(1'b0, FIT_BASIC);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_tests++;
            if ({if_min.sel_pop, if_min.sel_fit, if_min.busy, if_min.done} !== 50'd0) begin
                n_fail++;
                $display("FAIL reset_min cyc %0d: got pop=%h fit=%h busy=%b done=%b want all 0",
                         c, if_min.sel_pop, if_min.sel_fit, if_min.busy, if_min.done);
            end
            n_tests++;
            if ({if_max.sel_pop, if_max.sel_fit, if_max.busy, if_max.done} !== 50'd0) begin
                n_fail++;
                $display("FAIL reset_max cyc %0d: got pop=%h fit=%h busy=%b done=%b want all 0",
                         c, if_max.sel_pop, if_max.sel_fit, if_max.busy, if_max.done);
            end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, FIT_BASIC);
        tick();
        if_min.start = 1'b0;
        if_max.start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            n_tests++;
            if ({if_min.busy, if_min.done} !== {(j <= 8), (j == 8)}) begin
                n_fail++;
                $display("FAIL basic_timing j=%0d: got busy=%b done=%b want busy=%b done=%b",
                         j, if_min.busy, if_min.done, (j <= 8), (j == 8));
            end
            if (j < 11) tick();
        end
        n_tests++;
        if (if_min.sel_fit !== MIN_FIT_BASIC) begin
            n_fail++;
            $display("FAIL basic_min_fit: got %h want %h", if_min.sel_fit, MIN_FIT_BASIC);
        end
        n_tests++;
        if (if_min.sel_pop !== MIN_POP_BASIC) begin
            n_fail++;
            $display("FAIL basic_min_pop: got %h want %h", if_min.sel_pop, MIN_POP_BASIC);
        end
        n_tests++;
        if (if_max.sel_fit !== MAX_FIT_BASIC) begin
            n_fail++;
            $display("FAIL basic_max_fit: got %h want %h", if_max.sel_fit, MAX_FIT_BASIC);
        end
        n_tests++;
        if (if_max.sel_pop !== MAX_POP_BASIC) begin
            n_fail++;
            $display("FAIL basic_max_pop: got %h want %h", if_max.sel_pop, MAX_POP_BASIC);
        end
    endtask

    task automatic test_ties();
        int   cyc;
        logic seen;
        drive(1'b1, FIT_TIES);
        tick();
        if_min.start = 1'b0;
        if_max.start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (if_min.done === 1'b1) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ties_done_timeout: got no done in %0d cycles want done", cyc);
        end
        n_tests++;
        if ({if_min.sel_pop, if_min.sel_fit} !== {POP_TIE_RES, FIT_TIE_RES}) begin
            n_fail++;
            $display("FAIL ties_min: got pop=%h fit=%h want pop=%h fit=%h",
                     if_min.sel_pop, if_min.sel_fit, POP_TIE_RES, FIT_TIE_RES);
        end
        n_tests++;
        if ({if_max.sel_pop, if_max.sel_fit} !== {POP_TIE_RES, FIT_TIE_RES}) begin
            n_fail++;
            $display("FAIL ties_max: got pop=%h fit=%h want pop=%h fit=%h",
                     if_max.sel_pop, if_max.sel_fit, POP_TIE_RES, FIT_TIE_RES);
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        int n_done;
        n_done = 0;
        drive(1'b1, FIT_BASIC);
        tick();
        for (int j = 0; j < 30; j++) begin
            if (if_min.done === 1'b1) n_done++;
            n_tests++;
            if ({if_min.busy, if_min.done} !== {((j % 10) != 9), ((j % 10) == 8)}) begin
                n_fail++;
                $display("FAIL b2b_timing j=%0d: got busy=%b done=%b want busy=%b done=%b",
                         j, if_min.busy, if_min.done, ((j % 10) != 9), ((j % 10) == 8));
            end
            if (j < 8) begin
                n_tests++;
                if (if_min.sel_fit !== FIT_TIE_RES) begin
                    n_fail++;
                    $display("FAIL b2b_held j=%0d: got %h want %h", j, if_min.sel_fit, FIT_TIE_RES);
                end
            end
            if (j == 29) begin
                if_min.start = 1'b0;
                if_max.start = 1'b0;
            end
            tick();
        end
        n_tests++;
        if (n_done != 3) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 3", n_done);
        end
        n_tests++;
        if ({if_min.sel_pop, if_min.sel_fit, if_min.busy} !== {MIN_POP_BASIC, MIN_FIT_BASIC, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_result: got pop=%h fit=%h busy=%b want pop=%h fit=%h busy=0",
                     if_min.sel_pop, if_min.sel_fit, if_min.busy, MIN_POP_BASIC, MIN_FIT_BASIC);
        end
    endtask

    task automatic test_reset_mid_scan();
        int   cyc;
        logic seen;
        drive(1'b1, FIT_BASIC);
        tick();
        if_min.start = 1'b0;
        if_max.start = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (if_min.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_busy_before: got %b want 1", if_min.busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if ({if_min.sel_pop, if_min.sel_fit, if_min.busy, if_min.done} !== 50'd0) begin
                n_fail++;
                $display("FAIL midrst_cleared cyc %0d: got pop=%h fit=%h busy=%b done=%b want all 0",
                         c, if_min.sel_pop, if_min.sel_fit, if_min.busy, if_min.done);
            end
            tick();
        end
        if_min.start = 1'b1;
        if_max.start = 1'b1;
        tick();
        if_min.start = 1'b0;
        if_max.start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            if (if_min.done === 1'b1) seen = 1'b1;
            else begin
                n_tests++;
                if ({if_min.sel_pop, if_min.sel_fit} !== 48'd0) begin
                    n_fail++;
                    $display("FAIL midrst_pre_done cyc %0d: got pop=%h fit=%h want 0",
                             cyc, if_min.sel_pop, if_min.sel_fit);
                end
                tick();
                cyc++;
            end
        end
        n_tests++;
        if (!seen || cyc != 8) begin
            n_fail++;
            $display("FAIL midrst_done_latency: got seen=%b after %0d cycles want seen=1 after 8",
                     seen, cyc);
        end
        n_tests++;
        if ({if_min.sel_pop, if_min.sel_fit} !== {MIN_POP_BASIC, MIN_FIT_BASIC}) begin
            n_fail++;
            $display("FAIL midrst_min_result: got pop=%h fit=%h want pop=%h fit=%h",
                     if_min.sel_pop, if_min.sel_fit, MIN_POP_BASIC, MIN_FIT_BASIC);
        end
        n_tests++;
        if ({if_max.sel_pop, if_max.sel_fit} !== {MAX_POP_BASIC, MAX_FIT_BASIC}) begin
            n_fail++;
            $display("FAIL midrst_max_result: got pop=%h fit=%h want pop=%h fit=%h",
                     if_max.sel_pop, if_max.sel_fit, MAX_POP_BASIC, MAX_FIT_BASIC);
        end
        repeat (2) tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        test_reset();
        test_basic();
        test_ties();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
